ldmx_daq_drain: RTL and testbench

Readout sequencer that drains complete events from the `ldmx_daq` event buffer through its register-strobe port and streams them out as 32-bit words. It:

- polls the DAQ status word for a non-empty buffer;
- reads the event length and then each event word;
- releases the page by pulsing the advance-read command bit.

It sits on `axi_clk` between `ldmx_daq` and the downstream event-builder/DMA stream, replacing software polling.

---
 rtl/ldmx_daq_drain_pkg.sv | 31 +++
 rtl/ldmx_daq_drain_strobe.sv | 85 ++++++++
 rtl/ldmx_daq_drain.sv | 222 ++++++++++++++++++++++
 tb/tb_ldmx_daq_drain.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldmx_daq_drain_pkg.sv
// ldmx_daq_drain_pkg
// Shared definitions for the DAQ drain sequencer: FSM state encoding, the
// ldmx_daq register-map addresses it touches, the advance-read command word
// and the Status[1] field positions.
package ldmx_daq_drain_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_POLL      = 3'd1,
    ST_WAIT_POLL = 3'd2,
    ST_WORD_RD   = 3'd3,
    ST_WORD_OUT  = 3'd4,
    ST_ADVANCE   = 3'd5,
    ST_ERROR     = 3'd6
  } drain_state_e;

  localparam logic [11:0] STATUS1_ADDR = 12'h041;
  localparam logic [11:0] CMD1_ADDR    = 12'h001;
  localparam logic [11:0] BUF_BASE     = 12'h800;

  localparam logic [31:0] ADVANCE_CMD  = 32'h0000_0002;

  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_LEN_LSB   = 16;
  localparam int STAT_LEN_MSB   = 26;

  function automatic logic [10:0] status_len(input logic [31:0] status);
    return status[STAT_LEN_MSB:STAT_LEN_LSB];
  endfunction

endpackage

// File: rtl/ldmx_daq_drain_strobe.sv
// daq_strobe_master
// Runs one read or write transaction on the ldmx_daq register-strobe port.
// A start pulse requests a transaction using addr/wdata/we, which the caller
// holds until done or timeout. The strobe is only raised once both
// acknowledges are low, falls the cycle after the acknowledge is seen, and is
// abandoned after TIMEOUT cycles without one.
// Ports:
//   axi_clk, reset_n            clock, async active-low reset
//   start, we, addr, wdata      transaction request (start is a 1-cycle pulse)
//   m_rstr/m_raddr/m_rack/m_dout  DAQ read strobe port
//   m_wstr/m_waddr/m_din/m_wack   DAQ write strobe port
//   done                        acknowledge seen this cycle (strobe falls next)
//   timeout                     final timeout cycle (strobe falls next)
//   rdata                       read data, valid together with done
module daq_strobe_master #(
  parameter int TIMEOUT = 255
) (
  input  logic        axi_clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        we,
  input  logic [11:0] addr,
  input  logic [31:0] wdata,
  output logic        m_rstr,
  output logic [11:0] m_raddr,
  input  logic        m_rack,
  input  logic [31:0] m_dout,
  output logic        m_wstr,
  output logic [11:0] m_waddr,
  output logic [31:0] m_din,
  input  logic        m_wack,
  output logic        done,
  output logic        timeout,
  output logic [31:0] rdata
);

  localparam logic [15:0] TMR_LOAD = 16'(TIMEOUT);

  logic        pend;
  logic [15:0] tmr;
  logic        strobe;
  logic        ack;
  logic        can_issue;

  assign strobe    = m_rstr | m_wstr;
  assign ack       = (m_rstr & m_rack) | (m_wstr & m_wack);
  assign done      = ack;
  assign timeout   = strobe & ~ack & (tmr <= 16'd1);
  assign rdata     = m_dout;
  // Both acks must be low this cycle, so a new strobe always follows at least
  // one ack-low cycle after the previous transaction.
  assign can_issue = (start | pend) & ~strobe & ~m_rack & ~m_wack;

  always_ff @(posedge axi_clk or negedge reset_n) begin
    if (!reset_n) begin
      pend    <= 1'b0;
      tmr     <= 16'd0;
      m_rstr  <= 1'b0;
      m_raddr <= 12'd0;
      m_wstr  <= 1'b0;
      m_waddr <= 12'd0;
      m_din   <= 32'd0;
    end else if (can_issue) begin
      pend <= 1'b0;
      tmr  <= TMR_LOAD;
      if (we) begin
        m_wstr  <= 1'b1;
        m_waddr <= addr;
        m_din   <= wdata;
      end else begin
        m_rstr  <= 1'b1;
        m_raddr <= addr;
      end
    end else begin
      if (start) pend <= 1'b1;
      if (ack || timeout) begin
        m_rstr <= 1'b0;
        m_wstr <= 1'b0;
      end else if (strobe) begin
        tmr <= tmr - 16'd1;
      end
    end
  end

endmodule

// File: rtl/ldmx_daq_drain.sv
// ldmx_daq_drain
// Drains complete events out of the ldmx_daq event buffer: polls Status[1],
// reads the event length and words through the register-strobe port, streams
// the words out with valid/ready/last, then releases the page with the
// advance-read command.
// Ports:
//   axi_clk, reset_n             clock, async active-low reset
//   enable, clr_err              start permission (level), sticky-flag clear
//   m_rstr..m_wack               DAQ register-strobe port
//   out_data/out_valid/out_last/out_ready  event word stream
//   busy                         any state except IDLE and WAIT_POLL
//   err_timeout, err_len         sticky error flags
//   events_drained               pages released (wraps)
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for enable before the next status poll
// POLL      | reading Status[1] for empty flag and event length
// WAIT_POLL | buffer empty; counting POLL_INTERVAL before re-polling
// WORD_RD   | reading buffer word idx
// WORD_OUT  | presenting the word downstream until accepted
// ADVANCE   | writing the advance-read command to release the page
// ERROR     | handshake timed out; event abandoned, back to IDLE
module ldmx_daq_drain
  import ldmx_daq_drain_pkg::*;
#(
  parameter int POLL_INTERVAL = 64,
  parameter int MAX_WORDS     = 2048,
  parameter int TIMEOUT       = 255
) (
  input  logic        axi_clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        clr_err,
  output logic        m_rstr,
  output logic [11:0] m_raddr,
  input  logic        m_rack,
  input  logic [31:0] m_dout,
  output logic        m_wstr,
  output logic [11:0] m_waddr,
  output logic [31:0] m_din,
  input  logic        m_wack,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        err_timeout,
  output logic        err_len,
  output logic [31:0] events_drained
);

  localparam logic [15:0] POLL_LOAD = 16'(POLL_INTERVAL);
  localparam logic [11:0] MAX_LEN   = 12'(MAX_WORDS);

  drain_state_e state;
  logic         start_q;
  logic         we_q;
  logic [11:0]  addr_q;
  logic [31:0]  wdata_q;
  logic [10:0]  len_q;
  logic [10:0]  idx_q;
  logic         last_q;
  logic [15:0]  poll_tmr;

  logic         mst_done;
  logic         mst_timeout;
  logic [31:0]  mst_rdata;
  logic [10:0]  stat_len;

  assign stat_len = status_len(mst_rdata);

  daq_strobe_master #(.TIMEOUT(TIMEOUT)) u_strobe (
    .axi_clk (axi_clk),
    .reset_n (reset_n),
    .start   (start_q),
    .we      (we_q),
    .addr    (addr_q),
    .wdata   (wdata_q),
    .m_rstr  (m_rstr),
    .m_raddr (m_raddr),
    .m_rack  (m_rack),
    .m_dout  (m_dout),
    .m_wstr  (m_wstr),
    .m_waddr (m_waddr),
    .m_din   (m_din),
    .m_wack  (m_wack),
    .done    (mst_done),
    .timeout (mst_timeout),
    .rdata   (mst_rdata)
  );

  always_ff @(posedge axi_clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      start_q        <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= 12'd0;
      wdata_q        <= 32'd0;
      len_q          <= 11'd0;
      idx_q          <= 11'd0;
      last_q         <= 1'b0;
      poll_tmr       <= 16'd0;
      out_data       <= 32'd0;
      out_valid      <= 1'b0;
      out_last       <= 1'b0;
      busy           <= 1'b0;
      err_timeout    <= 1'b0;
      err_len        <= 1'b0;
      events_drained <= 32'd0;
    end else begin
      start_q <= 1'b0;
      // Placed before the case so a flag set below in the same cycle wins.
      if (clr_err) begin
        err_timeout <= 1'b0;
        err_len     <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (enable) begin
            state   <= ST_POLL;
            busy    <= 1'b1;
            start_q <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= STATUS1_ADDR;
          end
        end

        ST_POLL: begin
          if (mst_timeout) begin
            err_timeout <= 1'b1;
            state       <= ST_ERROR;
          end else if (mst_done) begin
            if (mst_rdata[STAT_EMPTY_BIT]) begin
              state    <= ST_WAIT_POLL;
              busy     <= 1'b0;
              poll_tmr <= POLL_LOAD;
            end else begin
              len_q <= stat_len;
              if (stat_len == 11'd0 || {1'b0, stat_len} > MAX_LEN) begin
                if (stat_len != 11'd0) err_len <= 1'b1;
                state   <= ST_ADVANCE;
                start_q <= 1'b1;
                we_q    <= 1'b1;
                addr_q  <= CMD1_ADDR;
                wdata_q <= ADVANCE_CMD;
              end else begin
                idx_q   <= 11'd0;
                state   <= ST_WORD_RD;
                start_q <= 1'b1;
                we_q    <= 1'b0;
                addr_q  <= BUF_BASE;
              end
            end
          end
        end

        ST_WAIT_POLL: begin
          if (poll_tmr <= 16'd1) state <= ST_IDLE;
          else poll_tmr <= poll_tmr - 16'd1;
        end

        ST_WORD_RD: begin
          if (mst_timeout) begin
            err_timeout <= 1'b1;
            state       <= ST_ERROR;
          end else if (mst_done) begin
            out_data  <= mst_rdata;
            out_valid <= 1'b1;
            out_last  <= (idx_q == len_q - 11'd1);
            last_q    <= (idx_q == len_q - 11'd1);
            state     <= ST_WORD_OUT;
          end
        end

        ST_WORD_OUT: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end else if (!out_valid && !m_rack) begin
            start_q <= 1'b1;
            if (last_q) begin
              state   <= ST_ADVANCE;
              we_q    <= 1'b1;
              addr_q  <= CMD1_ADDR;
              wdata_q <= ADVANCE_CMD;
            end else begin
              idx_q  <= idx_q + 11'd1;
              state  <= ST_WORD_RD;
              we_q   <= 1'b0;
              addr_q <= BUF_BASE + {1'b0, idx_q + 11'd1};
            end
          end
        end

        ST_ADVANCE: begin
          if (mst_timeout) begin
            err_timeout <= 1'b1;
            state       <= ST_ERROR;
          end else if (mst_done) begin
            events_drained <= events_drained + 32'd1;
            state          <= ST_IDLE;
            busy           <= 1'b0;
          end
        end

        ST_ERROR: begin
          // The strobe master has already dropped its strobe on the timeout.
          state <= ST_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ldmx_daq_drain.sv
module tb_ldmx_daq_drain;

  localparam int POLL = 16;
  localparam int MAXW = 1024;
  localparam int TMO  = 255;

  logic        axi_clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        clr_err;
  logic        m_rstr;
  logic [11:0] m_raddr;
  logic        m_rack = 1'b0;
  logic [31:0] m_dout = 32'd0;
  logic        m_wstr;
  logic [11:0] m_waddr;
  logic [31:0] m_din;
  logic        m_wack = 1'b0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        busy;
  logic        err_timeout;
  logic        err_len;
  logic [31:0] events_drained;

  ldmx_daq_drain #(.POLL_INTERVAL(POLL), .MAX_WORDS(MAXW), .TIMEOUT(TMO)) dut (
    .axi_clk(axi_clk), .reset_n(reset_n), .enable(enable), .clr_err(clr_err),
    .m_rstr(m_rstr), .m_raddr(m_raddr), .m_rack(m_rack), .m_dout(m_dout),
    .m_wstr(m_wstr), .m_waddr(m_waddr), .m_din(m_din), .m_wack(m_wack),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .err_timeout(err_timeout),
    .err_len(err_len), .events_drained(events_drained)
  );

  always #5 axi_clk = ~axi_clk;

  int total = 0;
  int bad   = 0;

  // Reference model: DAQ page contents and the expected output stream.
  int          q_len[$];
  logic [31:0] q_seed[$];
  logic [31:0] exp_words[$];
  logic        exp_last[$];
  int          exp_drained = 0;
  logic        exp_err_len = 1'b0;

  int          ready_mode = 0;
  bit          rack_stuck = 0;
  int          lat_cnt = 0;
  int          lat_tgt = 2;
  bit          rack_pending = 0;
  int          n_writes = 0;
  int          cyc = 0;
  int          poll_times[$];
  bit          prev_rstr = 0;
  bit          prev_wstr = 0;
  logic [11:0] prev_raddr = 12'd0;
  logic [11:0] prev_waddr = 12'd0;
  int          hi_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] seed, input int i);
    return seed + 32'(i) * 32'h9E37_79B9;
  endfunction

  task automatic add_words(input logic [31:0] seed, input int len);
    if (len > MAXW) exp_err_len = 1'b1;
    else for (int i = 0; i < len; i++) begin
      exp_words.push_back(word_of(seed, i));
      exp_last.push_back(i == len - 1);
    end
  endtask

  task automatic push_event(input int len);
    logic [31:0] s;
    s = $urandom;
    q_len.push_back(len);
    q_seed.push_back(s);
    exp_drained++;
    add_words(s, len);
  endtask

  task automatic rebuild_model();
    exp_words.delete();
    exp_last.delete();
    exp_drained = q_len.size();
    for (int e = 0; e < q_len.size(); e++) add_words(q_seed[e], q_len[e]);
  endtask

  function automatic logic [31:0] daq_read(input logic [11:0] a);
    logic [31:0] v;
    v = 32'd0;
    if (a == 12'h041) begin
      if (q_len.size() == 0) v = 32'h1;
      else v[26:16] = 11'(q_len[0]);
    end else if (a[11] && q_len.size() > 0) begin
      v = word_of(q_seed[0], int'(a[10:0]));
    end
    return v;
  endfunction

  task automatic daq_write(input logic [11:0] a, input logic [31:0] d);
    n_writes++;
    chk("adv_addr", 32'(a), 32'h001);
    chk("adv_data", d, 32'h2);
    if (a == 12'h001 && d == 32'h2 && q_len.size() > 0) begin
      void'(q_len.pop_front());
      void'(q_seed.pop_front());
    end
  endtask

  // DAQ responder, protocol monitor and stream sink, all away from posedge.
  always @(negedge axi_clk) begin
    cyc++;
    if (!reset_n) begin
      m_rack = 1'b0; m_wack = 1'b0; lat_cnt = 0; rack_pending = 0;
      prev_rstr = 0; prev_wstr = 0; hi_cnt = 0;
    end else begin
      if (rack_pending) begin
        chk("valid_after_rack", 32'(out_valid), 32'd1);
        rack_pending = 0;
      end
      chk("one_strobe", 32'(m_rstr & m_wstr), 32'd0);
      if (m_rstr && prev_rstr) chk("raddr_stable", 32'(m_raddr), 32'(prev_raddr));
      if (m_wstr && prev_wstr) chk("waddr_stable", 32'(m_waddr), 32'(prev_waddr));
      if (m_rstr && !prev_rstr && m_raddr == 12'h041) poll_times.push_back(cyc);
      if (m_rstr || m_wstr) hi_cnt++;
      else begin
        if (hi_cnt > 0 && rack_stuck) chk("timeout_cycles", 32'(hi_cnt), 32'(TMO));
        hi_cnt = 0;
      end
      prev_rstr = m_rstr; prev_wstr = m_wstr; prev_raddr = m_raddr; prev_waddr = m_waddr;

      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
      if (out_valid && out_ready) begin
        chk("word_pending", 32'(exp_words.size() > 0), 32'd1);
        if (exp_words.size() > 0) begin
          chk("word_data", out_data, exp_words.pop_front());
          chk("word_last", 32'(out_last), 32'(exp_last.pop_front()));
        end
      end

      if (m_rstr) begin
        if (!m_rack) begin
          if (!rack_stuck && lat_cnt >= lat_tgt) begin
            m_rack = 1'b1;
            m_dout = daq_read(m_raddr);
            if (m_raddr[11]) rack_pending = 1;
          end else lat_cnt++;
        end
      end else if (m_wstr) begin
        if (!m_wack) begin
          if (lat_cnt >= lat_tgt) begin
            m_wack = 1'b1;
            daq_write(m_waddr, m_din);
          end else lat_cnt++;
        end
      end else begin
        m_rack = 1'b0; m_wack = 1'b0; lat_cnt = 0;
        lat_tgt = $urandom_range(1, 4);
      end
    end
  end

  task automatic wait_drain(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge axi_clk);
      if (q_len.size() == 0 && exp_words.size() == 0 && busy == 1'b0) ok = 1;
    end
    chk("drain_in_time", 32'(ok), 32'd1);
  endtask

  task automatic pulse_clr();
    @(negedge axi_clk) clr_err = 1'b1;
    @(negedge axi_clk) clr_err = 1'b0;
  endtask

  initial begin
    int  n0;
    int  len;
    int  r;
    bit  seen;

    reset_n = 1'b0; enable = 1'b0; clr_err = 1'b0;
    repeat (3) @(negedge axi_clk);
    chk("rst_rstr", 32'(m_rstr), 32'd0);
    chk("rst_wstr", 32'(m_wstr), 32'd0);
    chk("rst_raddr", 32'(m_raddr), 32'd0);
    chk("rst_waddr", 32'(m_waddr), 32'd0);
    chk("rst_din", m_din, 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err_to", 32'(err_timeout), 32'd0);
    chk("rst_err_len", 32'(err_len), 32'd0);
    chk("rst_drained", events_drained, 32'd0);
    @(negedge axi_clk) reset_n = 1'b1;

    // Empty buffer: periodic polls, no writes, idle between polls.
    poll_times.delete();
    enable = 1'b1;
    repeat (100) @(negedge axi_clk);
    chk("empty_no_write", 32'(n_writes), 32'd0);
    chk("empty_polls", 32'(poll_times.size() >= 3), 32'd1);
    if (poll_times.size() >= 2)
      chk("poll_gap", 32'((poll_times[1] - poll_times[0]) >= POLL + 2 &&
                          (poll_times[1] - poll_times[0]) <= POLL + 12), 32'd1);
    n0 = poll_times.size(); seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge axi_clk);
      if (poll_times.size() > n0) seen = 1;
    end
    chk("poll_seen", 32'(seen), 32'd1);
    repeat (11) @(negedge axi_clk);
    chk("busy_between_polls", 32'(busy), 32'd0);

    // Single event of three words.
    push_event(3);
    wait_drain(500);
    chk("single_drained", events_drained, 32'(exp_drained));
    chk("single_writes", 32'(n_writes), 32'(exp_drained));

    // Back-pressure on word 1, with enable dropped mid-event.
    ready_mode = 2;
    push_event(3);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge axi_clk);
      if (out_valid) seen = 1;
    end
    chk("bp_valid_seen", 32'(seen), 32'd1);
    enable = 1'b0;
    repeat (20) begin
      @(negedge axi_clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", out_data, exp_words[0]);
      chk("bp_no_read", 32'(m_rstr), 32'd0);
    end
    ready_mode = 0;
    wait_drain(500);
    chk("bp_drained", events_drained, 32'(exp_drained));
    n0 = poll_times.size();
    repeat (60) @(negedge axi_clk);
    chk("disabled_no_poll", 32'(poll_times.size()), 32'(n0));
    chk("disabled_idle", 32'(busy), 32'd0);

    // Zero-length and oversize events.
    enable = 1'b1;
    push_event(0);
    push_event(2047);
    wait_drain(500);
    chk("zo_err_len", 32'(err_len), 32'(exp_err_len));
    chk("zo_drained", events_drained, 32'(exp_drained));
    chk("zo_writes", 32'(n_writes), 32'(exp_drained));
    pulse_clr();
    exp_err_len = 1'b0;
    chk("clr_err_len", 32'(err_len), 32'(exp_err_len));

    // Read acknowledge stuck low: timeout, no advance, then recovery.
    enable = 1'b0;
    repeat (40) @(negedge axi_clk);
    rack_stuck = 1;
    push_event(2);
    n0 = poll_times.size(); seen = 0;
    enable = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge axi_clk);
      if (poll_times.size() > n0) seen = 1;
    end
    chk("to_poll_seen", 32'(seen), 32'd1);
    enable = 1'b0;
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge axi_clk);
      if (err_timeout) seen = 1;
    end
    chk("to_flag", 32'(seen), 32'd1);
    chk("to_strobe_low", 32'(m_rstr), 32'd0);
    chk("to_no_advance", events_drained, 32'(exp_drained - 1));
    chk("to_no_write", 32'(n_writes), 32'(exp_drained - 1));
    repeat (3) @(negedge axi_clk);
    chk("to_idle", 32'(busy), 32'd0);
    pulse_clr();
    chk("clr_err_to", 32'(err_timeout), 32'd0);
    rack_stuck = 0;
    enable = 1'b1;
    wait_drain(500);
    chk("to_recovered", events_drained, 32'(exp_drained));

    // Randomized batch with random back-pressure.
    ready_mode = 1;
    for (int e = 0; e < 8; e++) begin
      r = $urandom_range(0, 9);
      if (r == 0) len = 0;
      else if (r == 1) len = $urandom_range(1025, 2047);
      else len = $urandom_range(1, 6);
      push_event(len);
    end
    wait_drain(6000);
    chk("rand_drained", events_drained, 32'(exp_drained));
    chk("rand_err_len", 32'(err_len), 32'(exp_err_len));
    chk("rand_writes", 32'(n_writes), 32'(exp_drained));

    // Reset during a word read.
    ready_mode = 0;
    push_event(5);
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge axi_clk);
      if (m_rstr && m_raddr >= 12'h801) seen = 1;
    end
    chk("rm_word_read_seen", 32'(seen), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rm_rstr", 32'(m_rstr), 32'd0);
    chk("rm_wstr", 32'(m_wstr), 32'd0);
    chk("rm_busy", 32'(busy), 32'd0);
    chk("rm_valid", 32'(out_valid), 32'd0);
    chk("rm_drained", events_drained, 32'd0);
    rebuild_model();
    n_writes = 0;
    @(negedge axi_clk) reset_n = 1'b1;
    wait_drain(800);
    chk("rm_after_drained", events_drained, 32'(exp_drained));
    chk("rm_after_writes", 32'(n_writes), 32'(exp_drained));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
